// File: rtl/adder_subtractor_multiprecision.sv
// Multi-cycle add/subtract over WORD_COUNT chunks of WORD_WIDTH bits, LSB chunk first,
// with a registered carry between chunks and valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for operands, input_ready high
// CALC  | one chunk per cycle, carry held in carry_q
// DONE  | result held, output_valid high until consumer takes it
module adder_subtractor_multiprecision #(
   parameter int WORD_WIDTH = 8,
   parameter int WORD_COUNT = 4,
   localparam int TOTAL_WIDTH = WORD_WIDTH * WORD_COUNT
) (
   input  logic                   clock,
   input  logic                   clear_n,
   input  logic                   input_valid,
   output logic                   input_ready,
   input  logic                   add_sub,
   input  logic                   carry_in,
   input  logic [TOTAL_WIDTH-1:0] A,
   input  logic [TOTAL_WIDTH-1:0] B,
   output logic                   output_valid,
   input  logic                   output_ready,
   output logic [TOTAL_WIDTH-1:0] sum,
   output logic                   carry_out,
   output logic [TOTAL_WIDTH-1:0] carries,
   output logic                   overflow
);

   localparam int CNT_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [TOTAL_WIDTH-1:0] a_q, b_q, sum_q, carries_q;
   logic                   carry_q, carry_out_q, overflow_q;
   logic                   accept, last_chunk;
   logic [WORD_WIDTH-1:0]  a_chunk, b_chunk, s_chunk, x_chunk;
   logic                   c_chunk;

   assign input_ready  = (state == IDLE) && clear_n;
   assign output_valid = (state == DONE);
   assign accept       = input_valid && input_ready;
   assign last_chunk   = (cnt == CNT_W'(WORD_COUNT - 1));

   assign a_chunk = a_q[int'(cnt)*WORD_WIDTH +: WORD_WIDTH];
   assign b_chunk = b_q[int'(cnt)*WORD_WIDTH +: WORD_WIDTH];
   assign {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk}
                             + (WORD_WIDTH+1)'(carry_q);
   // Carry into each bit recovered from the sum: a ^ b ^ s.
   assign x_chunk = a_chunk ^ b_chunk ^ s_chunk;

   always_ff @(posedge clock) begin
      if (!clear_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)       state_nxt = CALC;
         CALC:    if (last_chunk)   state_nxt = DONE;
         DONE:    if (output_ready) state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         cnt         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         sum_q       <= '0;
         carries_q   <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (accept) begin
         // Subtract is A + ~B + ~borrow_in, so invert B and the incoming carry.
         a_q     <= A;
         b_q     <= add_sub ? ~B : B;
         carry_q <= add_sub ? ~carry_in : carry_in;
         cnt     <= '0;
      end else if (state == CALC) begin
         sum_q[int'(cnt)*WORD_WIDTH +: WORD_WIDTH]     <= s_chunk;
         carries_q[int'(cnt)*WORD_WIDTH +: WORD_WIDTH] <= x_chunk;
         carry_q <= c_chunk;
         cnt     <= cnt + 1'b1;
         if (last_chunk) begin
            carry_out_q <= c_chunk;
            overflow_q  <= x_chunk[WORD_WIDTH-1] ^ c_chunk;
         end
      end
   end

   assign sum       = sum_q;
   assign carries   = carries_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_adder_subtractor_multiprecision.sv
// Bench for adder_subtractor_multiprecision (8-bit chunks, 4 chunks): directed vectors,
// expected results queued at accept and checked by a monitor on each output handshake.
module tb_adder_subtractor_multiprecision;

   localparam int WW = 8;
   localparam int WC = 4;
   localparam int TW = WW * WC;

   logic          clock = 1'b0;
   logic          clear_n;
   logic          input_valid, input_ready;
   logic          add_sub, carry_in;
   logic [TW-1:0] A, B;
   logic          output_valid, output_ready;
   logic [TW-1:0] sum, carries;
   logic          carry_out, overflow;

   adder_subtractor_multiprecision #(.WORD_WIDTH(WW), .WORD_COUNT(WC)) dut (
      .clock(clock), .clear_n(clear_n),
      .input_valid(input_valid), .input_ready(input_ready),
      .add_sub(add_sub), .carry_in(carry_in), .A(A), .B(B),
      .output_valid(output_valid), .output_ready(output_ready),
      .sum(sum), .carry_out(carry_out), .carries(carries), .overflow(overflow)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [TW-1:0] s;
      logic [TW-1:0] c;
      logic          co;
      logic          ov;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   pushed = 0;
   int   popped = 0;
   int   cyc    = 0;
   int   acc_cyc;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every result handshake pops one expectation.
   always @(negedge clock) begin
      if (output_valid && output_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got sum 0x%08h expected no result", sum);
         end else begin
            exp_t e;
            e = sb.pop_front();
            popped++;
            chk("sum", sum, e.s);
            chk("carries", carries, e.c);
            chk("carry_out", {31'd0, carry_out}, {31'd0, e.co});
            chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Presents operands until accepted; records the accept cycle and queues the expectation.
   task automatic issue(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic as,
                        input logic ci, input logic push, input exp_t e);
      logic r;
      logic done;
      done = 1'b0;
      A = a; B = b; add_sub = as; carry_in = ci; input_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         r = input_ready;
         tick();
         if (r) done = 1'b1;
      end
      input_valid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
      end
      acc_cyc = cyc;
      if (push) begin
         sb.push_back(e);
         pushed++;
      end
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 20 && !output_valid; i++) tick();
      chk({name, "_latency"}, TW'(cyc - acc_cyc), TW'(WC));
   endtask

   task automatic run_op(input string name, input logic [TW-1:0] a, input logic [TW-1:0] b,
                         input logic as, input logic ci, input exp_t e);
      issue(a, b, as, ci, 1'b1, e);
      wait_valid(name);
      tick();
      chk({name, "_handshake"}, {31'd0, output_valid}, 32'd0);
   endtask

   exp_t e;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_n = 1'b0; input_valid = 1'b0; output_ready = 1'b1;
      add_sub = 1'b0; carry_in = 1'b0; A = '0; B = '0;
      tick(); tick(); tick();
      chk("rst_input_ready", {31'd0, input_ready}, 32'd0);
      chk("rst_output_valid", {31'd0, output_valid}, 32'd0);
      chk("rst_sum", sum, 32'h0);
      chk("rst_carries", carries, 32'h0);
      chk("rst_flags", {30'd0, carry_out, overflow}, 32'd0);
      clear_n = 1'b1;
      #1;
      chk("rst_release_ready", {31'd0, input_ready}, 32'd1);

      e = '{s: 32'h0100_0000, c: 32'h01FF_FFFE, co: 1'b0, ov: 1'b0};
      run_op("add_chain", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, e);
      e = '{s: 32'hFFFF_FFFF, c: 32'h0000_0001, co: 1'b0, ov: 1'b0};
      run_op("sub_borrow", 32'h0, 32'h1, 1'b1, 1'b0, e);
      e = '{s: 32'h8000_0000, c: 32'hFFFF_FFFE, co: 1'b0, ov: 1'b1};
      run_op("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, e);
      e = '{s: 32'h7FFF_FFFF, c: 32'h0000_0001, co: 1'b1, ov: 1'b1};
      run_op("sub_ovf", 32'h8000_0000, 32'h1, 1'b1, 1'b0, e);
      e = '{s: 32'h1, c: 32'hFFFF_FFF8, co: 1'b1, ov: 1'b0};
      run_op("sub_bin", 32'd5, 32'd3, 1'b1, 1'b1, e);
      e = '{s: 32'h9, c: 32'h0000_000F, co: 1'b0, ov: 1'b0};
      run_op("add_cin", 32'd5, 32'd3, 1'b0, 1'b1, e);

      // Backpressure: result held while new operands wait outside IDLE.
      output_ready = 1'b0;
      e = '{s: 32'h2345_6789, c: 32'h2060_20E0, co: 1'b0, ov: 1'b0};
      issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, e);
      wait_valid("bp");
      A = 32'd2; B = 32'd3; add_sub = 1'b0; carry_in = 1'b0; input_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold_valid", {31'd0, output_valid}, 32'd1);
         chk("bp_no_ready", {31'd0, input_ready}, 32'd0);
         chk("bp_hold_sum", sum, 32'h2345_6789);
      end
      output_ready = 1'b1;
      tick();
      chk("bp_release_valid", {31'd0, output_valid}, 32'd0);
      chk("bp_release_ready", {31'd0, input_ready}, 32'd1);
      tick();
      acc_cyc = cyc;
      input_valid = 1'b0;
      sb.push_back('{s: 32'h5, c: 32'h4, co: 1'b0, ov: 1'b0});
      pushed++;
      wait_valid("bp_next");
      tick();

      // Reset after two chunks: operation discarded.
      issue(32'h1111_1111, 32'h1111_1111, 1'b0, 1'b0, 1'b0, e);
      tick(); tick();
      chk("partial_sum", sum, 32'h0000_2222);
      clear_n = 1'b0;
      tick();
      chk("abort_valid", {31'd0, output_valid}, 32'd0);
      chk("abort_sum", sum, 32'h0);
      chk("abort_carries", carries, 32'h0);
      chk("abort_ready_low", {31'd0, input_ready}, 32'd0);
      clear_n = 1'b1;
      #1;
      chk("abort_ready_high", {31'd0, input_ready}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("abort_no_result", {31'd0, output_valid}, 32'd0);
      end
      e = '{s: 32'h7, c: 32'h0, co: 1'b0, ov: 1'b0};
      run_op("post_rst", 32'd3, 32'd4, 1'b0, 1'b0, e);

      tick();
      chk("results_seen", TW'(popped), TW'(pushed));
      chk("queue_empty", TW'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
